// File: rtl/aes_ctr_req.sv
// aes_ctr_req: counter-owning initiator for the sliced AES CTR-mode increment
// protocol. Holds the 128-bit counter block, offers it on a valid/ready stream,
// requests an increment per accepted value, serves the counter FSM's slice
// reads and captures its slice writebacks.
// Optional feature macro: AES_CTR_REQ_WRAP_DETECT_EN (sticky wrap_o on a
// counter that rolled over to all-zeros); when undefined wrap_o is tied low.
module aes_ctr_req #(
  parameter  int unsigned SliceSize     = 16,
  parameter  int unsigned NumSlices     = 8,
  localparam int unsigned SliceIdxWidth = $clog2(NumSlices)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           iv_load_i,
  input  logic [SliceSize*NumSlices-1:0] iv_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [SliceSize*NumSlices-1:0] out_ctr_o,
  output logic                           incr_o,
  input  logic                           ready_i,
  input  logic [SliceIdxWidth-1:0]       ctr_slice_idx_i,
  output logic [SliceSize-1:0]           ctr_slice_o,
  input  logic [SliceSize-1:0]           ctr_slice_i,
  input  logic                           ctr_we_i,
  input  logic                           alert_i,
  output logic                           err_o,
  output logic                           wrap_o
);

  localparam logic [SliceIdxWidth:0] WcntFull = (SliceIdxWidth+1)'(NumSlices);

  typedef enum logic [2:0] {
    StIdle,
    StValid,
    StReq,
    StBusy,
    StError
  } state_e;

  state_e                                state_q, state_d;
  logic [NumSlices-1:0][SliceSize-1:0]   ctr_q, ctr_d;
  logic [SliceIdxWidth:0]                wcnt_q, wcnt_d;
  logic                                  out_valid_q, incr_q, err_q;

  // Slice read port for the counter FSM; no bypass of a same-cycle write.
  assign ctr_slice_o = ctr_q[ctr_slice_idx_i];
  assign out_ctr_o   = ctr_q;
  assign out_valid_o = out_valid_q;
  assign incr_o      = incr_q;
  assign err_o       = err_q;

  // Next-state, counter update and write-count logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d = state_q;
    ctr_d   = ctr_q;
    wcnt_d  = wcnt_q;

    if (alert_i) begin
      state_d = StError;
    end else begin
      unique case (state_q)
        StIdle, StValid: begin
          if (ctr_we_i) begin
            state_d = StError;
          end else if (iv_load_i) begin
            // A load beats a same-cycle handshake; that handshake is dropped.
            ctr_d   = iv_i;
            state_d = StValid;
          end else if (state_q == StValid && out_ready_i) begin
            state_d = StReq;
          end
        end

        StReq: begin
          wcnt_d = '0;
          if (ctr_we_i) begin
            state_d = StError;
          end else if (ready_i) begin
            state_d = StBusy;
          end
        end

        StBusy: begin
          if (ctr_we_i) begin
            if (wcnt_q == WcntFull) begin
              state_d = StError;
            end else begin
              ctr_d[ctr_slice_idx_i] = ctr_slice_i;
              wcnt_d                 = wcnt_q + 1'b1;
            end
          end
          if (state_d != StError && ready_i) begin
            state_d = (wcnt_d == WcntFull) ? StValid : StError;
          end
        end

        default: begin
          // StError is terminal; only reset leaves it.
          state_d = StError;
        end
      endcase
    end
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst_i) begin
      state_q     <= StIdle;
      ctr_q       <= '0;
      wcnt_q      <= '0;
      out_valid_q <= 1'b0;
      incr_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      wcnt_q      <= wcnt_d;
      out_valid_q <= (state_d == StValid);
      incr_q      <= (state_d == StReq);
      err_q       <= (state_d == StError);
    end
  end

`ifdef AES_CTR_REQ_WRAP_DETECT_EN
  logic wrap_q, wrap_set, wrap_clr;

  assign wrap_set = (state_q == StBusy) && (state_d == StValid) && (ctr_d == '0);
  assign wrap_clr = iv_load_i && (state_q inside {StIdle, StValid}) &&
                    (state_d == StValid);

  // Sticky wrap flag, cleared by an accepted IV load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrap_q <= 1'b0;
    end else if (wrap_clr) begin
      wrap_q <= 1'b0;
    end else if (wrap_set) begin
      wrap_q <= 1'b1;
    end
  end

  assign wrap_o = wrap_q;
`else
  assign wrap_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_ctr_req.sv
// tb_aes_ctr_req: table-driven and randomized checks of aes_ctr_req against a
// plain 128-bit arithmetic model, with a behavioural counter FSM driving the
// slice interface.
module tb_aes_ctr_req;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         iv_load_i;
  logic [127:0] iv_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] out_ctr_o;
  logic         incr_o;
  logic         ready_i;
  logic [2:0]   ctr_slice_idx_i;
  logic [15:0]  ctr_slice_o;
  logic [15:0]  ctr_slice_i;
  logic         ctr_we_i;
  logic         alert_i;
  logic         err_o;
  logic         wrap_o;

  int n_vec = 0;
  int n_err = 0;

  aes_ctr_req dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .iv_load_i       (iv_load_i),
    .iv_i            (iv_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_ctr_o       (out_ctr_o),
    .incr_o          (incr_o),
    .ready_i         (ready_i),
    .ctr_slice_idx_i (ctr_slice_idx_i),
    .ctr_slice_o     (ctr_slice_o),
    .ctr_slice_i     (ctr_slice_i),
    .ctr_we_i        (ctr_we_i),
    .alert_i         (alert_i),
    .err_o           (err_o),
    .wrap_o          (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [127:0] iv;
    logic [127:0] exp_ctr;
    logic         exp_wrap;  // value expected when wrap detection is built in
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic exp_wrap_of(input logic w);
`ifdef AES_CTR_REQ_WRAP_DETECT_EN
    return w;
`else
    return 1'b0 & w;
`endif
  endfunction

  task automatic do_reset;
    rst_i = 1'b1; iv_load_i = 1'b0; iv_i = '0; out_ready_i = 1'b0;
    ready_i = 1'b1; ctr_slice_idx_i = '0; ctr_slice_i = '0;
    ctr_we_i = 1'b0; alert_i = 1'b0;
    tick; tick;
    rst_i = 1'b0;
  endtask

  task automatic do_load(input logic [127:0] iv);
    iv_load_i = 1'b1; iv_i = iv;
    tick;
    iv_load_i = 1'b0;
    check("load_valid", out_valid_o, 1);
    check("load_ctr", out_ctr_o, iv);
    check("load_wrap_clr", wrap_o, 0);
  endtask

  // Accept the current counter and act as the counter FSM: stall ready_i for
  // 'stall' cycles, then perform n_writes slice read-modify-writes (ripple +1),
  // optionally pulsing iv_load_i on write number load_at, then return ready_i.
  task automatic run_incr(input int n_writes, input int stall, input int load_at,
                          input logic [127:0] load_iv);
    logic        carry;
    logic [16:0] sum;
    out_ready_i = 1'b1; ready_i = 1'b0;
    tick;
    out_ready_i = 1'b0;
    check("incr_t1", incr_o, 1);
    for (int s = 0; s < stall; s++) begin
      tick;
      check("incr_hold", incr_o, 1);
    end
    ready_i = 1'b1;
    tick;
    ready_i = 1'b0;
    carry = 1'b1;
    for (int i = 0; i < n_writes; i++) begin
      ctr_slice_idx_i = 3'(i);
      #1;
      sum = {1'b0, ctr_slice_o} + {16'd0, carry};
      ctr_slice_i = sum[15:0];
      carry = sum[16];
      ctr_we_i = 1'b1;
      iv_load_i = (i == load_at);
      iv_i = load_iv;
      tick;
      if (i == 0) check("incr_low_busy", incr_o, 0);
    end
    ctr_we_i = 1'b0; iv_load_i = 1'b0;
    check("no_early_valid", out_valid_o, 0);
    ready_i = 1'b1;
    tick;
  endtask

  initial begin
    logic [127:0] iv, exp;
    logic         exp_w;
    int           k, n_inc;

    vecs[0] = '{128'h0, 128'h1, 1'b0};
    vecs[1] = '{128'h0000_FFFF, 128'h0001_0000, 1'b0};
    vecs[2] = '{{128{1'b1}}, 128'h0, 1'b1};
    vecs[3] = '{128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF,
                128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0};
    vecs[4] = '{128'h1234_5678_9ABC_DEF0_0F0F_F0F0_AAAA_5555,
                128'h1234_5678_9ABC_DEF0_0F0F_F0F0_AAAA_5556, 1'b0};
    vecs[5] = '{128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE,
                {128{1'b1}}, 1'b0};

    // Reset state.
    do_reset;
    ctr_slice_idx_i = 3'd5;
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_incr", incr_o, 0);
    check("rst_err", err_o, 0);
    check("rst_wrap", wrap_o, 0);
    check("rst_ctr", out_ctr_o, 0);
    check("rst_slice", ctr_slice_o, 0);

    // Table-driven single increments.
    for (int v = 0; v < 6; v++) begin
      do_load(vecs[v].iv);
      run_incr(8, 0, -1, '0);
      check("tbl_valid", out_valid_o, 1);
      check("tbl_ctr", out_ctr_o, vecs[v].exp_ctr);
      check("tbl_err", err_o, 0);
      check("tbl_incr", incr_o, 0);
      check("tbl_wrap", wrap_o, exp_wrap_of(vecs[v].exp_wrap));
    end

    // Randomized loads and back-to-back increments against 128-bit arithmetic.
    for (int r = 0; r < 15; r++) begin
      iv = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, 8);
        for (int j = 0; j < k; j++) iv[j*16 +: 16] = 16'hFFFF;
      end
      do_load(iv);
      exp = iv;
      exp_w = 1'b0;
      n_inc = $urandom_range(1, 3);
      for (int n = 0; n < n_inc; n++) begin
        run_incr(8, $urandom_range(0, 2), -1, '0);
        exp = exp + 128'd1;
        exp_w = exp_w | (exp == 128'd0);
        check("rnd_valid", out_valid_o, 1);
        check("rnd_ctr", out_ctr_o, exp);
        check("rnd_err", err_o, 0);
        check("rnd_wrap", wrap_o, exp_wrap_of(exp_w));
      end
    end

    // ready_i held low in REQ for 5 cycles; iv_load_i during BUSY is ignored.
    iv = 128'hABCD_0000_1111_2222_3333_4444_5555_FFFF;
    do_load(iv);
    run_incr(8, 5, 3, 128'hDEAD_BEEF);
    check("stall_valid", out_valid_o, 1);
    check("stall_ctr", out_ctr_o, iv + 128'd1);
    check("stall_err", err_o, 0);

    // Load and accept in the same VALID cycle: load wins, no increment.
    iv_load_i = 1'b1; out_ready_i = 1'b1; iv_i = 128'h55;
    tick;
    iv_load_i = 1'b0; out_ready_i = 1'b0;
    check("ldacc_ctr", out_ctr_o, 128'h55);
    check("ldacc_valid", out_valid_o, 1);
    check("ldacc_incr", incr_o, 0);
    tick;
    check("ldacc_incr2", incr_o, 0);
    check("ldacc_ctr2", out_ctr_o, 128'h55);

    // Slice write while in VALID.
    ctr_we_i = 1'b1; ctr_slice_idx_i = 3'd0; ctr_slice_i = 16'h1234;
    tick;
    ctr_we_i = 1'b0;
    check("we_valid_err", err_o, 1);
    check("we_valid_vld", out_valid_o, 0);
    check("we_valid_ctr", out_ctr_o, 128'h55);

    // Short writeback: ready_i returns after 7 writes.
    do_reset;
    do_load(128'h0);
    run_incr(7, 0, -1, '0);
    check("short_err", err_o, 1);
    check("short_valid", out_valid_o, 0);
    check("short_incr", incr_o, 0);
    tick;
    check("short_sticky", err_o, 1);
    do_reset;
    check("short_rst_err", err_o, 0);
    check("short_rst_valid", out_valid_o, 0);
    check("short_rst_ctr", out_ctr_o, 0);
    do_load(128'h77);

    // Alert during BUSY.
    out_ready_i = 1'b1;
    tick;
    out_ready_i = 1'b0; ready_i = 1'b1;
    tick;
    ready_i = 1'b0;
    alert_i = 1'b1;
    tick;
    alert_i = 1'b0;
    check("alert_err", err_o, 1);
    check("alert_valid", out_valid_o, 0);
    check("alert_incr", incr_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
